// File: rtl/pc_sequencer.sv
// pc_sequencer: next-PC selection for the single-cycle RISC-V core (reset, halt, interrupt
// entry/return, redirect, stall, increment). Interrupt logic is built only with PC_SEQ_IRQ_EN.
module pc_sequencer #(
    parameter int unsigned         NrOfBits      = 32,
    parameter logic [NrOfBits-1:0] ResetVector   = 32'h0000_0000,
    parameter int unsigned         NrOfIrq       = 3,
    parameter logic [NrOfBits-1:0] IrqVectorBase = 32'h0000_0100
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic [NrOfBits-1:0] PcQ,
    input  logic                Stall,
    input  logic                Redirect,
    input  logic [NrOfBits-1:0] RedirectTarget,
    input  logic                Mret,
    input  logic                Halt,
    input  logic [NrOfIrq-1:0]  IrqReq,
    output logic [NrOfBits-1:0] PcNext,
    output logic                PcEn,
    output logic                Flush,
    output logic [NrOfIrq-1:0]  IrqAck,
    output logic [NrOfBits-1:0] Epc,
    output logic                Halted
);
    typedef enum logic [1:0] {ST_RUN, ST_ENTER, ST_HALT} state_t;

    localparam logic [NrOfBits-1:0] PcStep = NrOfBits'(4);

    state_t              state_reg, state_next;
    logic [NrOfBits-1:0] pc_inc;
    logic [NrOfBits-1:0] irq_vector;
    logic [NrOfBits-1:0] epc_value;
    logic                irq_ready;
    logic                mret_ok;
    logic                irq_take;
    logic                mret_take;

    assign pc_inc = PcQ + PcStep;

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_reg <= ST_RUN;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        PcNext     = PcQ;
        PcEn       = 1'b0;
        Flush      = 1'b0;
        Halted     = 1'b0;
        irq_take   = 1'b0;
        mret_take  = 1'b0;
        case (state_reg)
            ST_RUN: begin
                if (Halt) begin
                    state_next = ST_HALT;
                end else if (irq_ready && !Stall) begin
                    irq_take   = 1'b1;
                    PcNext     = irq_vector;
                    PcEn       = 1'b1;
                    state_next = ST_ENTER;
                end else if (mret_ok && !Stall) begin
                    mret_take = 1'b1;
                    PcNext    = epc_value;
                    PcEn      = 1'b1;
                end else if (Redirect && !Stall) begin
                    PcNext = RedirectTarget;
                    PcEn   = 1'b1;
                end else if (!Stall) begin
                    PcNext = pc_inc;
                    PcEn   = 1'b1;
                end
            end
            ST_ENTER: begin
                Flush      = 1'b1;
                state_next = ST_RUN;
            end
            ST_HALT: begin
                Halted = 1'b1;
            end
            default: begin
                state_next = ST_RUN;
            end
        endcase
        // Reset overrides everything so the PC register loads the vector on the same edge.
        if (!Reset) begin
            state_next = ST_RUN;
            PcNext     = ResetVector;
            PcEn       = 1'b1;
            Flush      = 1'b0;
            Halted     = 1'b0;
            irq_take   = 1'b0;
            mret_take  = 1'b0;
        end
    end

`ifdef PC_SEQ_IRQ_EN
    logic [NrOfIrq-1:0]  req_sync_reg;
    logic [NrOfIrq-1:0]  req_prev_reg;
    logic [NrOfIrq-1:0]  pend_reg;
    logic [NrOfIrq-1:0]  pend_next;
    logic [NrOfIrq-1:0]  rise;
    logic [NrOfIrq-1:0]  ack_onehot;
    logic                ie_reg, ie_next;
    logic [NrOfBits-1:0] epc_reg, epc_next;

    assign rise       = req_sync_reg & ~req_prev_reg;
    assign ack_onehot = irq_take ? (pend_reg & (~pend_reg + NrOfIrq'(1))) : '0;

    // A fresh edge in the same cycle as the ack keeps the bit set.
    for (genvar gi = 0; gi < NrOfIrq; gi++) begin : g_pend
        assign pend_next[gi] = (pend_reg[gi] & ~ack_onehot[gi]) | rise[gi];
    end

    always_comb begin
        irq_vector = IrqVectorBase;
        for (int i = NrOfIrq - 1; i >= 0; i--) begin
            if (pend_reg[i]) begin
                irq_vector = IrqVectorBase + NrOfBits'(4 * i);
            end
        end
    end

    assign irq_ready = ie_reg & (|pend_reg);
    assign mret_ok   = Mret;
    assign ie_next   = irq_take ? 1'b0 : (mret_take ? 1'b1 : ie_reg);
    assign epc_next  = irq_take ? (Redirect ? RedirectTarget : pc_inc) : epc_reg;
    assign epc_value = epc_reg;
    assign Epc       = epc_reg;
    assign IrqAck    = ack_onehot;

    always_ff @(posedge Clock) begin
        req_sync_reg <= IrqReq;
        if (!Reset) begin
            req_prev_reg <= IrqReq;
            pend_reg     <= '0;
            ie_reg       <= 1'b1;
            epc_reg      <= '0;
        end else begin
            req_prev_reg <= req_sync_reg;
            pend_reg     <= pend_next;
            ie_reg       <= ie_next;
            epc_reg      <= epc_next;
        end
    end
`else
    logic unused_irq;

    assign irq_ready  = 1'b0;
    assign mret_ok    = 1'b0;
    assign irq_vector = IrqVectorBase;
    assign epc_value  = '0;
    assign Epc        = '0;
    assign IrqAck     = '0;
    assign unused_irq = ^{IrqReq, Mret, irq_take, mret_take};
`endif

endmodule
